// File: rtl/sort_out_mc_if.sv
// sort_out_mc_if: multi-bank sorter output interface.
// Each bank's request is synchronized into src_clock, banks are served
// round-robin, and the RAM reads are streamed out through a 2-entry FIFO
// that absorbs sink backpressure.

// Per-bank request tracking: synchronizer, edge detect, pending, length, ack
module sort_out_mc_if_bank #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  src_clock,
   input  logic                  src_reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_len,
   input  logic                  i_grant,
   input  logic                  i_done,
   output logic                  o_eligible,
   output logic                  o_ack,
   output logic [ADDR_WIDTH-1:0] o_len
);
   logic [2:0]            r_sync;
   logic                  r_req_d;
   logic                  r_pending;
   logic                  r_ack;
   logic [ADDR_WIDTH-1:0] r_len;
   logic                  w_rise;

   assign w_rise     = r_sync[2] & ~r_req_d;
   assign o_eligible = r_pending & ~r_ack;
   assign o_ack      = r_ack;
   assign o_len      = r_len;

   // Synchronize request, latch length on its rising edge, track ack
   always_ff @(posedge src_clock or posedge src_reset) begin
      if (src_reset) begin
         r_sync    <= '0;
         r_req_d   <= 1'b0;
         r_pending <= 1'b0;
         r_ack     <= 1'b0;
         r_len     <= '0;
      end else begin
         r_sync  <= {r_sync[1:0], i_req};
         r_req_d <= r_sync[2];
         if (i_grant)
            r_pending <= 1'b0;
         // a fresh edge wins over the grant that consumes the old request
         if (w_rise) begin
            r_pending <= 1'b1;
            r_len     <= i_len;
         end
         if (i_done)
            r_ack <= 1'b1;
         else if (!r_sync[2])
            r_ack <= 1'b0;
      end
   end
endmodule

module sort_out_mc_if #(
   parameter  int DATA_WIDTH = 16,
   parameter  int MAX_LENGTH = 256,
   parameter  int NUM_BANKS  = 2,
   localparam int ADDR_WIDTH = $clog2(MAX_LENGTH),
   localparam int BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                             src_clock,
   input  logic                             src_reset,
   input  logic [NUM_BANKS-1:0]             snk_req,
   output logic [NUM_BANKS-1:0]             src_ack,
   input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  tran_len,
   output logic [BANK_WIDTH+ADDR_WIDTH-1:0] buf_rdaddress,
   output logic                             buf_rden,
   input  logic [DATA_WIDTH-1:0]            buf_q,
   output logic [DATA_WIDTH-1:0]            src_data,
   output logic [BANK_WIDTH-1:0]            src_channel,
   output logic                             src_sop,
   output logic                             src_eop,
   output logic                             src_valid,
   input  logic                             src_ready
);
   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

   state_t                                 r_state, w_next_state;
   logic [BANK_WIDTH-1:0]                  r_grant, r_ptr;
   logic [ADDR_WIDTH-1:0]                  r_offset;
   logic [NUM_BANKS-1:0]                   w_eligible;
   logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]   w_len;
   logic                                   w_any;
   logic [BANK_WIDTH-1:0]                  w_sel, w_idx;
   logic                                   w_start, w_issue, w_last, w_pop, w_push;
   logic [2:0]                             w_occ;
   logic                                   w_credit;

   // read tags travel alongside the 1-cycle RAM latency
   logic                                   r_rd_vld, r_rd_sop, r_rd_eop;
   logic [BANK_WIDTH-1:0]                  r_rd_ch;

   // 2-entry output FIFO
   logic [1:0][DATA_WIDTH-1:0]             r_fifo_data;
   logic [1:0]                             r_fifo_sop, r_fifo_eop;
   logic [1:0][BANK_WIDTH-1:0]             r_fifo_ch;
   logic                                   r_wr_ptr, r_rd_ptr;
   logic [1:0]                             r_count;
   logic                                   w_head_eop;

   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      sort_out_mc_if_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
         .src_clock  (src_clock),
         .src_reset  (src_reset),
         .i_req      (snk_req[i]),
         .i_len      (tran_len[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .i_grant    (w_start && (w_sel == BANK_WIDTH'(i))),
         .i_done     (w_pop && w_head_eop && (src_channel == BANK_WIDTH'(i))),
         .o_eligible (w_eligible[i]),
         .o_ack      (src_ack[i]),
         .o_len      (w_len[i])
      );
   end

   // Round-robin pick: first eligible bank at or after the pointer
   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      w_idx = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         w_idx = BANK_WIDTH'((int'(r_ptr) + k) % NUM_BANKS);
         if (!w_any && w_eligible[w_idx]) begin
            w_any = 1'b1;
            w_sel = w_idx;
         end
      end
   end

   assign w_pop      = src_valid & src_ready;
   assign w_push     = r_rd_vld;
   assign w_head_eop = r_fifo_eop[r_rd_ptr];
   // occupancy after this cycle's pop, counting the read still in flight
   assign w_occ      = {1'b0, r_count} - {2'b0, w_pop} + {2'b0, r_rd_vld};
   assign w_credit   = (w_occ < 3'd2);
   assign w_last     = (r_offset == w_len[r_grant]);

   // Next-state and read-issue decode
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_issue      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_start      = 1'b1;
               w_next_state = ST_READ;
            end
         end
         ST_READ: begin
            w_issue = w_credit;
            if (w_credit && w_last)
               w_next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_pop && w_head_eop)
               w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign buf_rden      = w_issue;
   assign buf_rdaddress = {r_grant, r_offset};

   // State register, grant/pointer latch and word offset counter
   always_ff @(posedge src_clock or posedge src_reset) begin
      if (src_reset) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_ptr    <= '0;
         r_offset <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_start) begin
            r_grant  <= w_sel;
            r_ptr    <= BANK_WIDTH'((int'(w_sel) + 1) % NUM_BANKS);
            r_offset <= '0;
         end else if (w_issue && !w_last) begin
            r_offset <= r_offset + 1'b1;
         end
      end
   end

   // Tag each read so framing lines up with buf_q one cycle later
   always_ff @(posedge src_clock or posedge src_reset) begin
      if (src_reset) begin
         r_rd_vld <= 1'b0;
         r_rd_sop <= 1'b0;
         r_rd_eop <= 1'b0;
         r_rd_ch  <= '0;
      end else begin
         r_rd_vld <= w_issue;
         r_rd_sop <= (r_offset == '0);
         r_rd_eop <= w_last;
         r_rd_ch  <= r_grant;
      end
   end

   // Output FIFO: write on returning RAM data, read on accepted beat
   always_ff @(posedge src_clock or posedge src_reset) begin
      if (src_reset) begin
         r_fifo_data <= '0;
         r_fifo_sop  <= '0;
         r_fifo_eop  <= '0;
         r_fifo_ch   <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= '0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= buf_q;
            r_fifo_sop[r_wr_ptr]  <= r_rd_sop;
            r_fifo_eop[r_wr_ptr]  <= r_rd_eop;
            r_fifo_ch[r_wr_ptr]   <= r_rd_ch;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign src_valid   = (r_count != 2'd0);
   assign src_data    = r_fifo_data[r_rd_ptr];
   assign src_channel = r_fifo_ch[r_rd_ptr];
   assign src_sop     = src_valid & r_fifo_sop[r_rd_ptr];
   assign src_eop     = src_valid & r_fifo_eop[r_rd_ptr];
endmodule

// File: tb/tb_sort_out_mc_if.sv
// Bench for sort_out_mc_if: RAM model, scoreboard of expected beats,
// table of single-bank packets plus hand-written multi-cycle sequences.
module tb_sort_out_mc_if;
   localparam int DW = 16;
   localparam int ML = 256;
   localparam int NB = 2;
   localparam int AW = 8;
   localparam int BW = 1;

   logic              src_clock = 1'b0;
   logic              src_reset;
   logic [NB-1:0]     snk_req;
   logic [NB-1:0]     src_ack;
   logic [NB*AW-1:0]  tran_len;
   logic [BW+AW-1:0]  buf_rdaddress;
   logic              buf_rden;
   logic [DW-1:0]     buf_q = '0;
   logic [DW-1:0]     src_data;
   logic [BW-1:0]     src_channel;
   logic              src_sop, src_eop, src_valid, src_ready;

   sort_out_mc_if #(.DATA_WIDTH(DW), .MAX_LENGTH(ML), .NUM_BANKS(NB)) dut (
      .src_clock     (src_clock),
      .src_reset     (src_reset),
      .snk_req       (snk_req),
      .src_ack       (src_ack),
      .tran_len      (tran_len),
      .buf_rdaddress (buf_rdaddress),
      .buf_rden      (buf_rden),
      .buf_q         (buf_q),
      .src_data      (src_data),
      .src_channel   (src_channel),
      .src_sop       (src_sop),
      .src_eop       (src_eop),
      .src_valid     (src_valid),
      .src_ready     (src_ready)
   );

   always #5 src_clock = ~src_clock;

   function automatic logic [DW-1:0] ram_word(input int b, input int o);
      return DW'(b * 4096 + 256 + o);
   endfunction

   // RAM model, one-cycle read latency
   always @(posedge src_clock)
      if (buf_rden)
         buf_q <= ram_word(int'(buf_rdaddress[AW +: BW]), int'(buf_rdaddress[AW-1:0]));

   typedef struct packed {
      logic [DW-1:0] d;
      logic          sop;
      logic          eop;
      logic [BW-1:0] ch;
   } beat_t;

   beat_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int rmode = 0;
   int cyc = 0;
   int nbeats = 0;
   int total_beats = 0;
   int sop_cyc = 0;
   int eop_cyc = 0;
   logic [DW-1:0] first_d = '0;
   logic [DW-1:0] last_d = '0;

   // sink ready pattern: 0 = always, 1 = toggle, 2 = random
   initial begin
      src_ready = 1'b1;
      forever begin
         @(posedge src_clock); #1;
         case (rmode)
            0:       src_ready = 1'b1;
            1:       src_ready = ~src_ready;
            default: src_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // monitor: scoreboard pop on each accepted beat, hold check under stall
   initial begin
      beat_t cur, pb, e;
      logic pv, pr;
      pv = 1'b0; pr = 1'b0; pb = '0;
      forever begin
         @(negedge src_clock);
         cyc++;
         cur = {src_data, src_sop, src_eop, src_channel};
         if (src_reset) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               checks++;
               if (!src_valid || cur != pb) begin
                  failures++;
                  $display("FAIL hold_stable: got v=%0b %h expected v=1 %h", src_valid, cur, pb);
               end
            end
            if (src_valid && src_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_beat: got %h expected none", cur);
               end else begin
                  e = exp_q.pop_front();
                  if (cur != e) begin
                     failures++;
                     $display("FAIL beat: got %h expected %h", cur, e);
                  end
               end
               if (src_sop) begin
                  first_d = src_data;
                  sop_cyc = cyc;
                  nbeats  = 0;
               end
               nbeats++;
               total_beats++;
               if (src_eop) begin
                  last_d  = src_data;
                  eop_cyc = cyc;
               end
            end
            pv = src_valid; pr = src_ready; pb = cur;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge src_clock); #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      check({name, "_ack"},   32'(src_ack), 0);
      check({name, "_rden"},  32'(buf_rden), 0);
      check({name, "_addr"},  32'(buf_rdaddress), 0);
      check({name, "_flags"}, 32'({src_valid, src_sop, src_eop}), 0);
      check({name, "_data"},  32'(src_data), 0);
      check({name, "_chan"},  32'(src_channel), 0);
   endtask

   task automatic push_pkt(input int b, input int len);
      for (int o = 0; o <= len; o++)
         exp_q.push_back({ram_word(b, o), (o == 0), (o == len), BW'(b)});
   endtask

   task automatic raise(input int b, input int len);
      tran_len[b*AW +: AW] = AW'(len);
      snk_req[b] = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         @(negedge src_clock);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout: got %0d beats left expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_ack(input logic [NB-1:0] mask, input int maxc);
      int n = 0;
      while ((src_ack & mask) != mask && n < maxc) begin
         @(negedge src_clock);
         n++;
      end
      check("ack_rise", 32'(src_ack & mask), 32'(mask));
   endtask

   // drop requests (called just after a rising edge) and time the ack fall
   task automatic release_reqs(input logic [NB-1:0] mask);
      snk_req = snk_req & ~mask;
      repeat (4) @(negedge src_clock);
      check("ack_hold", 32'(src_ack & mask), 32'(mask));
      @(negedge src_clock);
      check("ack_fall", 32'(src_ack & mask), 0);
   endtask

   typedef struct {
      int            bank;
      int            len;
      int            mode;
      int            exp_beats;
      logic [DW-1:0] exp_first;
      logic [DW-1:0] exp_last;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{0,   7, 0,   8, 16'h0100, 16'h0107};
      vecs[1] = '{0,   7, 1,   8, 16'h0100, 16'h0107};
      vecs[2] = '{1,   0, 0,   1, 16'h1100, 16'h1100};
      vecs[3] = '{1, 255, 0, 256, 16'h1100, 16'h11FF};
      vecs[4] = '{0,   3, 2,   4, 16'h0100, 16'h0103};
      vecs[5] = '{1,   5, 2,   6, 16'h1100, 16'h1105};

      src_reset = 1'b1;
      snk_req   = '0;
      tran_len  = '0;
      repeat (3) @(negedge src_clock);
      check_zero("reset");
      tick();
      src_reset = 1'b0;
      tick(2);

      // request-to-read and read-to-valid latency on a 2-word packet
      push_pkt(0, 1);
      raise(0, 1);
      repeat (5) @(negedge src_clock);
      check("lat_rden_early", 32'(buf_rden), 0);
      @(negedge src_clock);
      check("lat_rden_first", 32'({buf_rden, buf_rdaddress}), 32'({1'b1, 9'h000}));
      @(negedge src_clock);
      check("lat_rden_second", 32'({buf_rden, buf_rdaddress}), 32'({1'b1, 9'h001}));
      @(negedge src_clock);
      check("lat_valid", 32'({src_valid, src_sop, buf_rden}), 32'b110);
      wait_drain("lat", 50);
      wait_ack(2'b01, 8);
      tick();
      release_reqs(2'b01);

      // single-bank packet table
      for (int i = 0; i < 6; i++) begin
         rmode = vecs[i].mode;
         tick();
         push_pkt(vecs[i].bank, vecs[i].len);
         raise(vecs[i].bank, vecs[i].len);
         wait_drain("vec", 2000);
         check("vec_beats", 32'(nbeats), 32'(vecs[i].exp_beats));
         check("vec_first", 32'(first_d), 32'(vecs[i].exp_first));
         check("vec_last",  32'(last_d),  32'(vecs[i].exp_last));
         if (vecs[i].mode == 0)
            check("vec_no_bubble", 32'(eop_cyc - sop_cyc), 32'(vecs[i].exp_beats - 1));
         wait_ack(NB'(1 << vecs[i].bank), 8);
         rmode = 0;
         tick();
         release_reqs(NB'(1 << vecs[i].bank));
      end

      // both banks at once after a reset-equivalent pointer at bank 0
      tick();
      push_pkt(0, 3);
      push_pkt(1, 3);
      raise(0, 3);
      raise(1, 3);
      wait_drain("dual_a", 200);
      wait_ack(2'b11, 8);
      tick();
      release_reqs(2'b11);

      // bank 0 alone moves the pointer to bank 1; then both at once
      tick();
      push_pkt(0, 2);
      raise(0, 2);
      wait_drain("solo0", 200);
      wait_ack(2'b01, 8);
      tick();
      release_reqs(2'b01);
      tick();
      push_pkt(1, 3);
      push_pkt(0, 3);
      raise(0, 3);
      raise(1, 3);
      wait_drain("dual_b", 200);
      wait_ack(2'b11, 8);
      tick();
      release_reqs(2'b11);

      // reset in the middle of a packet while the request stays high
      tick();
      begin
         int base, n;
         base = total_beats;
         n = 0;
         push_pkt(0, 7);
         raise(0, 7);
         while (total_beats < base + 3 && n < 100) begin
            @(negedge src_clock);
            n++;
         end
         check("mid_reach_beat3", 32'(total_beats >= base + 3), 1);
      end
      tick();
      src_reset = 1'b1;
      #1;
      check_zero("mid_reset");
      exp_q.delete();
      tick(2);
      src_reset = 1'b0;
      push_pkt(0, 7);
      wait_drain("resend", 200);
      check("resend_beats", 32'(nbeats), 8);
      check("resend_first", 32'(first_d), 32'h0100);
      wait_ack(2'b01, 8);
      tick();
      release_reqs(2'b01);

      tick(10);
      check("final_queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sort_out_mc_if.md
# sort_out_mc_if

Multi-bank successor to the single-buffer sorter output interface. Serves NUM_BANKS independent dual-port RAM buffer banks, each filled in the write clock domain and announced by its own four-phase req/ack handshake. Reads the banks round-robin and emits one packet per request as a streaming source with sop/eop/channel. Unlike its predecessor, honours sink backpressure (src_ready). Sits between the sorter buffer RAMs and the downstream stream consumer in the src_clock domain.

## Interface
- DATA_WIDTH, 16, stream/RAM word width
- MAX_LENGTH, 256, max words per packet per bank; ADDR_WIDTH = clog2(MAX_LENGTH) (localparam)
- NUM_BANKS, 2, number of buffer banks/channels; BANK_WIDTH = max(1, clog2(NUM_BANKS)) (localparam)

- src_clock  in  1  clock
- src_reset  in  1  reset, asynchronous, active-high
- snk_req  in  NUM_BANKS  per-bank request from write domain (asynchronous to src_clock)
- src_ack  out  NUM_BANKS  per-bank acknowledge, registered
- tran_len  in  NUM_BANKS*ADDR_WIDTH  per-bank length field; bank i at [i*ADDR_WIDTH +: ADDR_WIDTH]; packet = tran_len+1 words
- buf_rdaddress  out  BANK_WIDTH+ADDR_WIDTH  {bank, word offset}
- buf_rden  out  1  RAM read enable; buf_q valid exactly 1 cycle later
- buf_q  in  DATA_WIDTH  RAM read data
- src_data  out  DATA_WIDTH  stream data
- src_channel  out  BANK_WIDTH  source bank of current word
- src_sop, src_eop, src_valid  out  1 each  stream framing/valid
- src_ready  in  1  sink ready; beat transfers when src_valid & src_ready

## Operation
- Per bank: 3-flop synchronizer on snk_req[i] (reset to 0), plus edge register; rising edge of synchronized req sets pending[i] and captures len[i] from tran_len slice in the same cycle. tran_len must be stable while snk_req high.
- Bank eligible when pending[i] & !ack[i]. Round-robin: search starts at (last granted + 1) mod NUM_BANKS; after reset pointer at bank 0.
- FSM: ST_IDLE -> ST_READ when any bank eligible (grant latched, pending[grant] cleared, offset counter cleared). ST_READ: issue read at {grant, offset} whenever credit allows; offset increments per issued read; after read of offset == len[grant], -> ST_DRAIN. ST_DRAIN: wait until eop beat transfers -> ST_IDLE.
- Credit: issue only if (fifo_count - pop + inflight) < 2; pop = src_valid & src_ready; inflight = buf_rden of previous cycle.
- Output: 2-entry FIFO of {data, sop, eop, channel}; written the cycle buf_q is valid. sop tagged on offset 0, eop on offset len. Head drives outputs; src_valid = fifo_count != 0.
- Ack: ack[i] set cycle after eop beat of bank i transfers; cleared the cycle after synchronized req[i] observed low. New request for bank i requires a fresh rising edge after ack[i] falls.
- Reset mid-operation: all state, FIFO, pending, acks, synchronizers cleared immediately; in-progress packet discarded with no eop. A snk_req held high across reset release is seen as a new rising edge.

## Timing
- Reset values: src_ack=0, buf_rden=0, buf_rdaddress=0, src_valid=0, src_sop=0, src_eop=0, src_data=0, src_channel=0.
- snk_req rise to pending: 4 src_clock cycles. Pending to first buf_rden: 1 cycle (IDLE->READ). buf_rden to src_valid: 2 cycles.
- With src_ready held high: 1 word/cycle, packet of N words occupies N consecutive valid cycles; no bubbles.
- src_ready low: outputs held stable while src_valid & !src_ready; reads stall, never overflow, no word lost/duplicated.
- Back-to-back packets from different banks: next ST_READ starts cycle after eop transfer; ack and next packet overlap.
- tran_len=0: single beat, sop=eop=1. tran_len=MAX_LENGTH-1: offset reaches all-ones, no wrap.
- Simultaneous rising edges on several banks: all set pending; served in round-robin order.

## Test plan
- Bank 0, tran_len=7, ready=1, RAM = offset+0x100 -> 8 consecutive beats 0x100..0x107, sop on first, eop on last, channel=0; src_ack[0] high until req dropped, then low 1 cycle after sync.
- Same packet, src_ready toggling 1/0 each cycle -> identical 8-word sequence, outputs stable during ready=0, no gaps beyond ready-low cycles.
- Banks 0 and 1 request same cycle, tran_len=3 each -> bank 0 packet then bank 1 packet back-to-back, channel 0 then 1; then bank 0 again requests while 1 requests -> after 1 served last, 0 next.
- tran_len=0 on bank 1 -> one beat, sop=eop=1, channel=1, ack[1] asserted.
- tran_len=255, ready=1 -> 256 beats, addresses {bank,0..255}, eop on 256th only.
- src_reset asserted mid-packet (beat 3 of 8) while req held -> all outputs 0 immediately; after release, full 8-beat packet re-sent from offset 0.
